// File: rtl/serv_dbus_rdata_if.sv
// Data-bus read-response bundle between the bus return path and the serial load unit.
// The master side drives the bus response and the shift enable; the slave side returns the serial bit and status.
interface serv_dbus_rdata_if;
  logic        i_ack;
  logic [31:0] i_dat;
  logic [1:0]  i_lsb;
  logic [1:0]  i_size;
  logic        i_signed;
  logic        i_en;
  logic        o_rd;
  logic        o_busy;
  logic        o_done;
  logic        o_overrun;

  modport master (
    output i_ack, i_dat, i_lsb, i_size, i_signed, i_en,
    input  o_rd, o_busy, o_done, o_overrun
  );

  modport slave (
    input  i_ack, i_dat, i_lsb, i_size, i_signed, i_en,
    output o_rd, o_busy, o_done, o_overrun
  );
endinterface

// File: rtl/serv_dbus_rdata.sv
// Captures a 32-bit bus read, aligns/extends it by size and offset, and shifts it out LSB-first.
// Bit 0 valid the cycle after i_ack; i_en low stalls in place; i_ack while busy is dropped and flagged sticky.
module serv_dbus_rdata (
  input  logic              i_clk,
  input  logic              i_rst_n,
  serv_dbus_rdata_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HOLD, SHIFT, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic        ext_q, ext_d;
  logic        ovr_q, ovr_d;

  logic [31:0] aligned;
  logic [31:0] masked;
  logic        cap_ext;
  logic        in_width;
  logic        busy;

  // Zero-filled shift supplies the missing upper bytes of misaligned accesses.
  always_comb begin
    aligned = bus.i_dat >> {bus.i_lsb, 3'b000};
    masked  = aligned;
    cap_ext = 1'b0;
    case (bus.i_size)
      2'b00: begin
        masked  = {24'b0, aligned[7:0]};
        cap_ext = bus.i_signed & aligned[7];
      end
      2'b01: begin
        masked  = {16'b0, aligned[15:0]};
        cap_ext = bus.i_signed & aligned[15];
      end
      default: begin
        masked  = aligned;
        cap_ext = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_width = 1'b1;
    case (size_q)
      2'b00:   in_width = (cnt_q[4:3] == 2'b00);
      2'b01:   in_width = ~cnt_q[4];
      default: in_width = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    ext_d   = ext_q;
    ovr_d   = ovr_q | (bus.i_ack && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (bus.i_ack) begin
          state_d = HOLD;
          data_d  = masked;
          cnt_d   = 5'd0;
          size_d  = bus.i_size;
          ext_d   = cap_ext;
        end
      end
      HOLD, SHIFT: begin
        if (bus.i_en) begin
          data_d  = {1'b0, data_q[31:1]};
          cnt_d   = cnt_q + 5'd1;
          state_d = (cnt_q == 5'd31) ? DONE : SHIFT;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      data_q  <= 32'd0;
      cnt_q   <= 5'd0;
      size_q  <= 2'b00;
      ext_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      ext_q   <= ext_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy          = (state_q == HOLD) || (state_q == SHIFT);
  assign bus.o_busy    = busy;
  assign bus.o_done    = (state_q == DONE);
  assign bus.o_rd      = busy ? (in_width ? data_q[0] : ext_q) : 1'b0;
  assign bus.o_overrun = ovr_q;

endmodule

// File: tb/tb_serv_dbus_rdata.sv
// Directed bench for serv_dbus_rdata: hand-computed load results, stalls, overrun and mid-shift reset.
module tb_serv_dbus_rdata;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  serv_dbus_rdata_if bus ();

  serv_dbus_rdata dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_ack    = 1'b0;
    bus.i_dat    = 32'd0;
    bus.i_lsb    = 2'd0;
    bus.i_size   = 2'd0;
    bus.i_signed = 1'b0;
    bus.i_en     = 1'b0;
  endtask

  // Capture one load (i_en deliberately high in the capture cycle), shift it out, check result and done timing.
  task automatic run_load(input string tag, input logic [31:0] dat, input logic [1:0] lsb,
                          input logic [1:0] size, input logic sgn, input bit stall,
                          input bit ovr, input logic [31:0] exp);
    logic [31:0] res;
    logic        v;
    res          = 32'd0;
    bus.i_ack    = 1'b1;
    bus.i_dat    = dat;
    bus.i_lsb    = lsb;
    bus.i_size   = size;
    bus.i_signed = sgn;
    bus.i_en     = 1'b1;
    tick();
    idle_inputs();
    chk({tag, "_busy"}, {31'd0, bus.o_busy}, 32'd1);
    if (ovr) begin
      bus.i_ack    = 1'b1;
      bus.i_dat    = 32'hFFFF_FFFF;
      bus.i_size   = 2'b10;
      bus.i_signed = 1'b1;
      tick();
      idle_inputs();
      chk({tag, "_ovr_set"}, {31'd0, bus.o_overrun}, 32'd1);
      chk({tag, "_ovr_busy"}, {31'd0, bus.o_busy}, 32'd1);
    end
    for (int b = 0; b < 32; b++) begin
      res[b] = bus.o_rd;
      chk({tag, "_nodone"}, {31'd0, bus.o_done}, 32'd0);
      bus.i_en = 1'b1;
      tick();
      if (stall && b < 31) begin
        for (int s = 0; s < 2; s++) begin
          bus.i_en = 1'b0;
          v = bus.o_rd;
          tick();
          chk({tag, "_stall_rd"}, {31'd0, bus.o_rd}, {31'd0, v});
          chk({tag, "_stall_done"}, {31'd0, bus.o_done}, 32'd0);
        end
      end
    end
    bus.i_en = 1'b0;
    chk({tag, "_done"}, {31'd0, bus.o_done}, 32'd1);
    chk({tag, "_done_busy"}, {31'd0, bus.o_busy}, 32'd0);
    tick();
    chk({tag, "_done_clr"}, {31'd0, bus.o_done}, 32'd0);
    chk({tag, "_idle_rd"}, {31'd0, bus.o_rd}, 32'd0);
    chk({tag, "_result"}, res, exp);
    if (ovr) chk({tag, "_ovr_sticky"}, {31'd0, bus.o_overrun}, 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_done", {31'd0, bus.o_done}, 32'd0);
    chk("rst_rd", {31'd0, bus.o_rd}, 32'd0);
    chk("rst_ovr", {31'd0, bus.o_overrun}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_load("ubyte", 32'h1280_3456, 2'd2, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0000_0080);
    run_load("sbyte", 32'h1280_3456, 2'd2, 2'b00, 1'b1, 1'b0, 1'b0, 32'hFFFF_FF80);
    run_load("shalf", 32'h8001_1234, 2'd2, 2'b01, 1'b1, 1'b0, 1'b0, 32'hFFFF_8001);
    run_load("word_stall", 32'hDEAD_BEEF, 2'd0, 2'b10, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    run_load("mis_half", 32'hA500_0000, 2'd3, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0000_00A5);
    run_load("word11", 32'h8765_4321, 2'd0, 2'b11, 1'b1, 1'b0, 1'b0, 32'h8765_4321);
    run_load("ovr", 32'h0000_5A00, 2'd1, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0000_005A);

    // Reset after 10 consumed bits: partial result dropped, no done pulse, overrun cleared.
    bus.i_ack  = 1'b1;
    bus.i_dat  = 32'hFFFF_FFFF;
    bus.i_size = 2'b10;
    tick();
    idle_inputs();
    bus.i_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", {31'd0, bus.o_busy}, 32'd1);
    chk("mid_rd", {31'd0, bus.o_rd}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("mrst_rd", {31'd0, bus.o_rd}, 32'd0);
    chk("mrst_done", {31'd0, bus.o_done}, 32'd0);
    chk("mrst_ovr", {31'd0, bus.o_overrun}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_nodone", {31'd0, bus.o_done}, 32'd0);
    end
    bus.i_en = 1'b0;
    tick();
    run_load("after_rst", 32'h0000_00C3, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0000_00C3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serv_dbus_rdata.md
# serv_dbus_rdata

Bit-serial load-data deserializer's counterpart: captures the parallel 32-bit data-bus read response, aligns it to the byte lane selected by the two address LSBs, and sign- or zero-extends it to 32 bits. It then shifts the result out LSB-first, one bit per enabled cycle, into the bit-serial core's register write path. It sits between the data-bus return path and the serial datapath, completing the load that the buffer register's address generation started.

## Interface
Parameters:
- none

Ports (clock and reset first):
- i_clk  input  1  core clock; all state updates on rising edge
- i_rst_n  input  1  reset; synchronous, active-low (fixed decision)
- i_ack  input  1  data-bus read acknowledge; i_dat valid this cycle
- i_dat  input  32  data-bus read data
- i_lsb  input  2  byte offset of the load address, sampled on accepted i_ack
- i_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word; sampled on accepted i_ack
- i_signed  input  1  1 = sign-extend, 0 = zero-extend; sampled on accepted i_ack
- i_en  input  1  serial shift enable from core sequencer
- o_rd  output  1  current serial result bit (LSB-first)
- o_busy  output  1  result held or shifting
- o_done  output  1  one-cycle pulse after the 32nd bit is consumed
- o_overrun  output  1  sticky: i_ack arrived while not IDLE

## Operation
- FSM states: IDLE, HOLD, SHIFT, DONE.
- IDLE: i_ack high -> capture, go HOLD. i_en ignored. o_rd = 0.
- Capture: aligned = i_dat >> (8*i_lsb), zero-filled from the top. Width mask from i_size: byte keeps [7:0], half keeps [15:0], word keeps [31:0].
- Capture, extension bit: i_signed ? aligned[7] (byte) / aligned[15] (half) : 0. Extension is unused for word loads.
- Misaligned half/word (e.g. half at lsb 3) is not trapped here. Missing upper bytes come from the zero-fill, then masking and extension apply as above; misalignment traps are handled upstream.
- HOLD: waits for i_en. First i_en -> SHIFT; that same cycle counts as bit 0 consumed.
- SHIFT: each cycle with i_en high, shift data register right by 1 and increment the 5-bit counter. i_en low -> hold all state (stall).
- SHIFT exit: the consuming cycle with counter = 31 -> DONE.
- o_rd in HOLD/SHIFT: data[0] while counter < width (8/16/32), else the extension bit.
- DONE: o_done = 1 for exactly this cycle, o_busy = 0. Next cycle -> IDLE unconditionally.
- i_ack in HOLD, SHIFT or DONE: data is discarded, state is unaffected, o_overrun is set. o_overrun clears only on reset.
- Counter arithmetic: 5-bit, wraps 31 -> 0 on the DONE transition. Counter is cleared on capture.

## Timing
- Reset (i_rst_n low at an edge): state IDLE, counter 0, data 0, o_rd 0, o_busy 0, o_done 0, o_overrun 0. This applies from any state, including mid-SHIFT; the partial result is lost and no o_done is generated.
- Capture latency: i_ack at edge N -> o_busy = 1 and bit 0 valid on o_rd after edge N.
- Shift: with continuous i_en from cycle N+1, bits 0..31 appear on o_rd in cycles N+1..N+32. o_done is high in cycle N+33. The next i_ack is accepted from cycle N+34 (IDLE).
- o_rd is combinational from registered state only; no i_en -> o_rd path.
- o_busy = state in {HOLD, SHIFT}. o_done and o_busy are never high together.
- Simultaneous i_ack and i_en in IDLE: capture only, i_en ignored.
- Simultaneous i_ack and last shift: overrun set, DONE still entered.

## Test plan
- Unsigned byte: i_dat=0x12803456, lsb=2, size=00, signed=0, i_en held high -> 32 serial bits assemble to 0x00000080; o_done pulses at N+33.
- Signed byte: same stimulus with signed=1 -> 0xFFFFFF80. Signed half: i_dat=0x80011234, lsb=2, size=01 -> 0xFFFF8001.
- Word with stalls: i_dat=0xDEADBEEF, lsb=0, size=10, i_en toggling 1,0,0,1,... -> result 0xDEADBEEF; o_rd holds its value on stalled cycles; o_done only after 32 enabled cycles.
- Misaligned half: i_dat=0xA5000000, lsb=3, size=01, signed=1 -> 0x000000A5 (bit 15 = 0, zero extension).
- Reset mid-SHIFT after 10 bits -> next cycle o_busy=0, o_rd=0, no o_done. A new i_ack is then accepted normally.
- Overrun: i_ack during HOLD with i_dat=0xFFFFFFFF -> o_overrun=1 and stays 1. The original captured result shifts out unchanged.
